// File: rtl/key_event_encoder.sv
// Press-edge detector, priority encoder and event FIFO for the 16-key pad.
// Optional auto-repeat of a held key is compiled in with `define KEY_REPEAT_EN.
module key_event_encoder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [15:0]                   key_deb,
    input  logic                          ev_ready,
    input  logic                          ovf_clr,
    output logic                          ev_valid,
    output logic [3:0]                    ev_code,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          key_held,
    output logic                          multi_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   key_prev;
    logic [15:0]   new_press;
    logic          new_any;
    logic          multi;
    logic [3:0]    press_code;
    logic          push;
    logic [3:0]    push_code;

    assign new_press = key_deb & ~key_prev;
    assign new_any   = |new_press;
    // x & (x-1) is nonzero exactly when more than one bit is set
    assign multi     = |(new_press & (new_press - 16'd1));

    always_comb begin
        press_code = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (new_press[i-1]) press_code = 4'(i - 1);
        end
    end

`ifdef KEY_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t  state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [3:0]  rep_code, rep_code_nxt;
    logic        rep_push;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            rep_code <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rep_code <= rep_code_nxt;
        end
    end

    // A fresh press always restarts the delay and masks any repeat due this cycle
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rep_code_nxt = rep_code;
        rep_push     = 1'b0;
        if (new_any) begin
            state_nxt    = DELAY;
            rep_code_nxt = press_code;
            cnt_nxt      = '0;
        end else begin
            case (state)
                IDLE: ;
                DELAY: begin
                    if (!key_deb[rep_code]) begin
                        state_nxt = IDLE;
                    end else if (cnt == 32'(REPEAT_DELAY - 1)) begin
                        rep_push  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                REPEAT: begin
                    if (!key_deb[rep_code]) begin
                        state_nxt = IDLE;
                    end else if (cnt == 32'(REPEAT_RATE - 1)) begin
                        rep_push = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign push      = new_any | rep_push;
    assign push_code = new_any ? press_code : rep_code;
`else
    logic unused_rep;

    assign unused_rep = REPEAT_DELAY[0] ^ REPEAT_RATE[0];
    assign push       = new_any;
    assign push_code  = press_code;
`endif

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, wr_en, drop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts
    assign wr_en    = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign ev_code  = ev_valid ? mem[rd_ptr] : '0;
    assign ev_count = count;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_prev  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            key_prev  <= key_deb;
            key_held  <= |key_deb;
            multi_err <= multi;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_event_encoder.sv
// Scoreboard bench for key_event_encoder: expected codes queued at stimulus time,
// compared on every pop. Build with +define+KEY_REPEAT_EN to cover auto-repeat.
module tb_key_event_encoder;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] key_deb;
    logic        ev_ready;
    logic        ovf_clr;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic [2:0]  ev_count;
    logic        key_held;
    logic        multi_err;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [3:0]  sb [$];
    int          pop_cyc [$];

    key_event_encoder #(
        .FIFO_DEPTH  (4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_deb  (key_deb),
        .ev_ready (ev_ready),
        .ovf_clr  (ovf_clr),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_count (ev_count),
        .key_held (key_held),
        .multi_err(multi_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pop monitor: the pop takes effect at the next posedge
    always @(negedge clk) begin
        if (rstn && ev_valid && ev_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_pop", ev_valid, 0);
            end else begin
                check("pop_code", ev_code, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input bit exp_push);
        key_deb = 16'(1 << k);
        if (exp_push) sb.push_back(4'(k));
        step();
        key_deb = '0;
        step();
    endtask

    task automatic drain(input int n);
        ev_ready = 1'b1;
        repeat (n) step();
        ev_ready = 1'b0;
    endtask

    initial begin
        int ofs [6] = '{0, 10, 14, 18, 22, 26};
        int exp_n;

        rstn     = 1'b0;
        key_deb  = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ev_valid, 0);
        check("rst_code", ev_code, 0);
        check("rst_count", ev_count, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi_err, 0);
        check("rst_ovf", overflow, 0);
        rstn = 1'b1;
        step();

        // single press, one-edge latency, then pop
        key_deb = 16'h0020;
        sb.push_back(4'd5);
        step();
        check("single_valid", ev_valid, 1);
        check("single_code", ev_code, 5);
        check("single_count", ev_count, 1);
        check("single_held", key_held, 1);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check("single_popped_valid", ev_valid, 0);
        check("single_popped_count", ev_count, 0);
        key_deb = '0;
        step();
        check("release_held", key_held, 0);
        check("release_no_event", ev_count, 0);

        // simultaneous presses: lowest wins, multi_err pulses once
        key_deb = 16'h0410;
        sb.push_back(4'd4);
        step();
        check("multi_code", ev_code, 4);
        check("multi_pulse", multi_err, 1);
        step();
        check("multi_pulse_end", multi_err, 0);
        drain(1);
        key_deb = 16'h0010;
        step();
        key_deb = 16'h0410;
        sb.push_back(4'd10);
        step();
        check("repress_code", ev_code, 10);
        check("repress_multi", multi_err, 0);
        drain(1);
        key_deb = '0;
        step();

        // fill to full, then a drop
        for (int k = 1; k <= 5; k++) press(k, k <= 4);
        check("full_count", ev_count, 4);
        check("full_ovf", overflow, 1);
        check("hold_code", ev_code, sb[0]);
        step();
        check("hold_code_again", ev_code, sb[0]);
        // drop and clear together: the drop wins
        key_deb = 16'h0040;
        ovf_clr = 1'b1;
        step();
        key_deb = '0;
        ovf_clr = 1'b0;
        check("set_wins", overflow, 1);
        check("set_wins_count", ev_count, 4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        // push and pop while full
        ev_ready = 1'b1;
        key_deb  = 16'h0080;
        sb.push_back(4'd7);
        step();
        ev_ready = 1'b0;
        key_deb  = '0;
        check("fullpop_count", ev_count, 4);
        check("fullpop_ovf", overflow, 0);
        drain(4);
        check("drained_count", ev_count, 0);
        check("drained_sb", sb.size(), 0);

        // reset mid-operation with a key still held
        press(6, 1'b1);
        key_deb = 16'h0008;
        sb.push_back(4'd3);
        step();
        check("pre_rst_count", ev_count, 2);
        rstn = 1'b0;
        #1;
        check("midrst_count", ev_count, 0);
        check("midrst_valid", ev_valid, 0);
        sb.delete();
        step();
        rstn = 1'b1;
        sb.push_back(4'd3);
        step();
        check("post_rst_count", ev_count, 1);
        check("post_rst_code", ev_code, 3);
        key_deb = '0;
        drain(1);

        // long hold of key 9
`ifdef KEY_REPEAT_EN
        exp_n = 6;
`else
        exp_n = 1;
`endif
        pop_cyc.delete();
        ev_ready = 1'b1;
        key_deb  = 16'h0200;
        for (int i = 0; i < exp_n; i++) sb.push_back(4'd9);
        repeat (30) step();
        key_deb = '0;
        repeat (10) step();
        ev_ready = 1'b0;
        check("hold_events", pop_cyc.size(), exp_n);
        for (int i = 1; i < pop_cyc.size() && i < exp_n; i++)
            check("hold_offset", pop_cyc[i] - pop_cyc[0], ofs[i]);
        check("final_sb", sb.size(), 0);
        check("final_count", ev_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Sits directly downstream of the 16-key debounce filter in the display/keypad path.
- Consumes the debounced level vector (1 = key pressed).
- Detects press edges and priority-encodes them to a 4-bit key code.
- Buffers codes in a small FIFO with a valid/ready interface for the display/entry logic.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2
REPEAT_DELAY, 25_000_000, cycles a key is held before the first auto-repeat (KEY_REPEAT_EN only)
REPEAT_RATE, 5_000_000, cycles between subsequent auto-repeats (KEY_REPEAT_EN only)

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
key_deb  input  16  debounced key levels, bit i = key i pressed
ev_ready  input  1  consumer accepts head event this cycle
ovf_clr  input  1  clears overflow flag
ev_valid  output  1  FIFO non-empty
ev_code  output  4  key code at FIFO head
ev_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
key_held  output  1  registered OR of key_deb
multi_err  output  1  one-cycle pulse: more than one new press in same cycle
overflow  output  1  sticky: an event was dropped

Behaviour:
- Reset (async, rstn=0):
  - key_prev=0, FIFO empty.
  - ev_valid=0, ev_code=0, ev_count=0.
  - key_held=0, multi_err=0, overflow=0.
  - Repeat FSM in IDLE.
- Edge detection:
  - new_press = key_deb & ~key_prev.
  - key_prev <= key_deb every cycle.
  - Releases generate no events.
- Encoding:
  - Push code = index of the lowest set bit of new_press.
  - If popcount(new_press) > 1, only the lowest index is pushed and multi_err pulses high for exactly 1 cycle.
- Latency:
  - key_deb bit rises before edge N → push at edge N.
  - ev_valid=1 and ev_code valid after edge N.
- FIFO:
  - Pop on ev_valid && ev_ready.
  - ev_code is driven from the head entry; it holds stable while ev_valid=1 and ev_ready=0.
  - Push and pop in the same cycle:
    - When full: both occur, count unchanged, no overflow.
    - When empty: push only (the pop has no effect since ev_valid=0).
  - Push when full without pop: event dropped, overflow <= 1.
  - overflow clears only on ovf_clr=1 or reset. If ovf_clr=1 and a drop occur in the same cycle, overflow stays 1 (set wins).
  - Pointers wrap modulo FIFO_DEPTH.
- key_held <= |key_deb (1-cycle registered).
- Reset mid-operation: all queued events are lost. A key still held after reset release produces a fresh press event, since key_prev=0.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: a repeat FSM with states IDLE, DELAY, REPEAT and a 32-bit counter.
  - IDLE → DELAY on any push; rep_code <= pushed code; counter=0.
  - DELAY: counter increments while key_deb[rep_code]=1 and new_press=0. On counter==REPEAT_DELAY-1, push rep_code again, counter=0, go to REPEAT.
  - REPEAT: same hold conditions. Push rep_code every REPEAT_RATE cycles.
  - Release of rep_code → IDLE.
  - A new press restarts DELAY with the new code.
  - A repeat push in the same cycle as a new press is suppressed; the new press wins.
  - Repeat pushes obey the same FIFO-full/overflow rules.
- Undefined: no repeat logic. REPEAT_DELAY and REPEAT_RATE are unused. Exactly one event per press.

Test Plan:
- Reset, key_deb=16'h0000, ev_ready=0 → all outputs 0.
- key_deb 0→16'h0020 → after the next edge: ev_valid=1, ev_code=5, ev_count=1. Pulse ev_ready for one cycle → ev_valid=0, ev_count=0.
- key_deb 0→16'h0410 in one cycle → ev_code=4, multi_err high for exactly 1 cycle. Releasing and re-pressing only bit 10 → ev_code=10.
- ev_ready=0, FIFO_DEPTH=4, press/release keys 1,2,3,4,5 → ev_count=4, overflow=1. Pops return 1,2,3,4. ovf_clr=1 → overflow=0.
- FIFO full, ev_ready=1 and a new press of key 7 in the same cycle → ev_count stays 4, overflow stays 0, and 7 is the last code popped.
- KEY_REPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=4, ev_ready=1, hold key 9 for 30 cycles → code 9 events at 0, +10, +14, +18, +22, +26 cycles after the first. None after release.
